reaction_bcd_converter: RTL and testbench
=========================================

# reaction_bcd_converter

Sequential binary-to-BCD converter sitting between the reaction-game timer/state-machine and the four seven-segment digit decoders. It replaces the combinational divide/modulo digit extraction with an iterative shift-and-add-3 (double-dabble) engine. On a start request it captures the elapsed seconds and milliseconds and produces four decimal digits: seconds, deciseconds, centiseconds and milliseconds. It holds the last result stable for display while a new conversion runs.

## Interface
- MSEC_WIDTH, 10, width of the binary millisecond input; also the number of shift iterations per conversion.
- SEC_WIDTH, 4, width of the binary seconds input.
- clk  input  1  system clock (50 MHz).
- reset  input  1  synchronous, active-high reset; clock clk.
- start  input  1  conversion request; sampled only when idle.
- sec_bin  input  SEC_WIDTH  elapsed seconds, legal range 0..9.
- msec_bin  input  MSEC_WIDTH  elapsed milliseconds, legal range 0..999.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new digits are registered.
- valid  output  1  high once at least one conversion has completed since reset.
- err  output  1  registered with the digits; high if the captured inputs were out of range.
- digit_s  output  4  seconds digit.
- digit_ds  output  4  deciseconds digit.
- digit_cs  output  4  centiseconds digit.
- digit_ms  output  4  milliseconds digit.

## Operation
- The FSM has three states: IDLE, SHIFT and LOAD.
- **IDLE**
  - If start=1: capture sec_bin and msec_bin.
  - Load the working register as {12'b0, msec_bin}.
  - Load the iteration counter with MSEC_WIDTH, then go to SHIFT.
  - If start=0: remain in IDLE.
- **SHIFT**, once per cycle:
  - For each of the three BCD nibbles (hundreds, tens, units) that is ≥5, add 3.
  - Shift the whole register left by 1 and decrement the counter.
  - When the counter reaches 1 on this cycle's shift, go to LOAD.
- **LOAD**
  - Register digit_ds = hundreds, digit_cs = tens, digit_ms = units, digit_s = captured sec (low 4 bits).
  - Set valid=1 and pulse done=1, then return to IDLE.
- **Range check**: if the captured sec > 9 or msec > 999:
  - LOAD writes all four digits as 4'hF and sets err=1.
  - The conversion still takes the full latency.
  - Otherwise LOAD clears err.
- The BCD nibbles are 4 bits wide. The add-3 correction is applied before the shift, never after. The working register is 12 + MSEC_WIDTH bits.
- Digit outputs, err and valid change only in LOAD. During SHIFT the previous result stays on the outputs, so the display never shows intermediate values.
- start while busy=1 is ignored: no queuing, no restart.
- start in the same cycle that done=1 is accepted, because the FSM is in IDLE that cycle.
- Inputs may change freely after the start cycle; only the captured copies are used.

## Timing
- Reset values: state IDLE, busy=0, done=0, valid=0, err=0, all digits 4'd0.
- reset has priority over every other input.
- Reset mid-conversion aborts the conversion with no done pulse and clears all outputs on the next edge.
- Start sampled on edge N:
  - busy=1 from after edge N through edge N+MSEC_WIDTH (SHIFT occupies edges N+1..N+MSEC_WIDTH).
  - LOAD is processed on edge N+MSEC_WIDTH+1; digits, err, valid and done become visible after that edge.
  - busy=0 in the done cycle.
- Latency from start to done is MSEC_WIDTH+1 cycles (11 with default parameters).
- Maximum throughput is one conversion per MSEC_WIDTH+2 cycles (start re-asserted during the done cycle).
- done is exactly one cycle wide, and only after a completed, non-aborted conversion.

## Test plan
- **Reset:** hold reset 3 cycles, then release with start=0 → all digits 0, valid=0, busy=0, done never asserts.
- **Nominal conversion:** sec_bin=1, msec_bin=234, one-cycle start → busy high 10 cycles; done pulses exactly 11 cycles after the start edge; digits 1/2/3/4; err=0; valid=1.
- **Boundary values:**
  - sec_bin=9, msec_bin=999 → digits 9/9/9/9, err=0.
  - Then sec_bin=0, msec_bin=0 → digits 0/0/0/0.
  - Then msec_bin=7 → 0/0/0/7.
- **Out of range:**
  - msec_bin=1000, sec_bin=0 → digits F/F/F/F, err=1 after 11 cycles.
  - Next conversion with sec_bin=10, msec_bin=5 → F/F/F/F, err=1.
  - Then sec_bin=2, msec_bin=50 → 2/0/5/0, err=0.
- **start while busy:**
  - start with msec=123, then start again 4 cycles later with msec=456 → single done; digits show 123.
  - start asserted during the done cycle with msec=456 → accepted; done after a further 11 cycles; digits 456.
  - Previous digits hold unchanged throughout each SHIFT phase.
- **Reset mid-conversion:** start with msec=888, assert reset on cycle 5 → no done pulse; digits 0, valid=0, busy=0; a subsequent start converts normally.

Source files
------------

// File: rtl/reaction_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : reaction_bcd_converter
// Purpose  : Iterative double-dabble conversion of elapsed sec/msec to 4 BCD digits.
// Revision : 1.0
// ============================================================================
module reaction_bcd_converter #(
  parameter int MSEC_WIDTH = 10,
  parameter int SEC_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SEC_WIDTH-1:0]  sec_bin,
  input  logic [MSEC_WIDTH-1:0] msec_bin,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic                  err,
  output logic [3:0]            digit_s,
  output logic [3:0]            digit_ds,
  output logic [3:0]            digit_cs,
  output logic [3:0]            digit_ms
);

  localparam int WORK_W = 12 + MSEC_WIDTH;
  localparam int CNT_W  = $clog2(MSEC_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WORK_W-1:0]     work_q, work_d;
  logic [WORK_W-1:0]     adj_work;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEC_WIDTH-1:0]  sec_q, sec_d;
  logic [MSEC_WIDTH-1:0] msec_q, msec_d;
  logic [3:0]            dig_s_q, dig_s_d, dig_ds_q, dig_ds_d;
  logic [3:0]            dig_cs_q, dig_cs_d, dig_ms_q, dig_ms_d;
  logic                  err_q, err_d, valid_q, valid_d, done_q, done_d;
  logic                  out_of_range;

  assign out_of_range = (32'(sec_q) > 32'd9) || (32'(msec_q) > 32'd999);

  // Add-3 correction on each BCD nibble, applied before the shift.
  always_comb begin
    adj_work = work_q;
    for (int i = 0; i < 3; i++) begin
      if (work_q[MSEC_WIDTH + 4*i +: 4] >= 4'd5) begin
        adj_work[MSEC_WIDTH + 4*i +: 4] = work_q[MSEC_WIDTH + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    sec_d    = sec_q;
    msec_d   = msec_q;
    dig_s_d  = dig_s_q;
    dig_ds_d = dig_ds_q;
    dig_cs_d = dig_cs_q;
    dig_ms_d = dig_ms_q;
    err_d    = err_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sec_d   = sec_bin;
          msec_d  = msec_bin;
          work_d  = {12'b0, msec_bin};
          cnt_d   = CNT_W'(MSEC_WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = {adj_work[WORK_W-2:0], 1'b0};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (out_of_range) begin
          dig_s_d  = 4'hF;
          dig_ds_d = 4'hF;
          dig_cs_d = 4'hF;
          dig_ms_d = 4'hF;
          err_d    = 1'b1;
        end else begin
          dig_s_d  = 4'(sec_q);
          dig_ds_d = work_q[MSEC_WIDTH + 8 +: 4];
          dig_cs_d = work_q[MSEC_WIDTH + 4 +: 4];
          dig_ms_d = work_q[MSEC_WIDTH +: 4];
          err_d    = 1'b0;
        end
        valid_d = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      sec_q    <= '0;
      msec_q   <= '0;
      dig_s_q  <= 4'd0;
      dig_ds_q <= 4'd0;
      dig_cs_q <= 4'd0;
      dig_ms_q <= 4'd0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      sec_q    <= sec_d;
      msec_q   <= msec_d;
      dig_s_q  <= dig_s_d;
      dig_ds_q <= dig_ds_d;
      dig_cs_q <= dig_cs_d;
      dig_ms_q <= dig_ms_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign valid    = valid_q;
  assign err      = err_q;
  assign digit_s  = dig_s_q;
  assign digit_ds = dig_ds_q;
  assign digit_cs = dig_cs_q;
  assign digit_ms = dig_ms_q;

endmodule
`default_nettype wire

// File: tb/tb_reaction_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reaction_bcd_converter
// Purpose  : Scoreboard bench for reaction_bcd_converter with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_reaction_bcd_converter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] sec_bin = 4'd0;
  logic [9:0] msec_bin = 10'd0;
  logic       busy, done, valid, err;
  logic [3:0] digit_s, digit_ds, digit_cs, digit_ms;

  typedef struct {
    logic [15:0] dig;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  logic [15:0] last_dig = 16'h0000;

  reaction_bcd_converter #(.MSEC_WIDTH(10), .SEC_WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sec_bin  (sec_bin),
    .msec_bin (msec_bin),
    .busy     (busy),
    .done     (done),
    .valid    (valid),
    .err      (err),
    .digit_s  (digit_s),
    .digit_ds (digit_ds),
    .digit_cs (digit_cs),
    .digit_ms (digit_ms)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives start for one cycle; caller must be positioned just after a rising edge.
  task automatic do_start(input logic [3:0] s, input logic [9:0] ms,
                          input logic push, input logic [15:0] dig, input logic e);
    exp_t x;
    sec_bin  = s;
    msec_bin = ms;
    start    = 1'b1;
    if (push) begin
      x.dig = dig;
      x.err = e;
      x.cyc = cyc + 12;
      sb.push_back(x);
    end
    @(posedge clk); #1;
    start    = 1'b0;
    sec_bin  = 4'hA;
    msec_bin = 10'h3FF;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL wait_done: got timeout after %0d cycles expected done pulse", limit);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_digits"}, {16'h0, digit_s, digit_ds, digit_cs, digit_ms}, 32'h0);
    chk({tag, "_valid"}, {31'h0, valid}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_err"}, {31'h0, err}, 32'h0);
    chk({tag, "_done"}, {31'h0, done}, 32'h0);
  endtask

  // Monitor: pops scoreboard on done, checks busy length and display hold.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_cnt = 0;
      last_dig = 16'h0000;
    end else begin
      if (busy) begin
        busy_cnt++;
        tests++;
        if ({digit_s, digit_ds, digit_cs, digit_ms} !== last_dig) begin
          fails++;
          $display("FAIL hold: got %h expected %h", {digit_s, digit_ds, digit_cs, digit_ms}, last_dig);
        end
      end else if (busy_cnt != 0) begin
        tests++;
        if (busy_cnt != 10) begin
          fails++;
          $display("FAIL busy_len: got %0d expected 10", busy_cnt);
        end
        busy_cnt = 0;
      end
      if (done) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          if ({digit_s, digit_ds, digit_cs, digit_ms} !== e.dig || err !== e.err ||
              valid !== 1'b1 || cyc != e.cyc) begin
            fails++;
            $display("FAIL result: got dig=%h err=%b valid=%b cyc=%0d expected dig=%h err=%b valid=1 cyc=%0d",
                     {digit_s, digit_ds, digit_cs, digit_ms}, err, valid, cyc, e.dig, e.err, e.cyc);
          end
          last_dig = e.dig;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_cleared("reset");
    repeat (4) @(posedge clk);
    #1;
    chk_cleared("idle");

    do_start(4'd1, 10'd234, 1'b1, 16'h1234, 1'b0);  wait_done(20);
    @(posedge clk); #1;
    do_start(4'd9, 10'd999, 1'b1, 16'h9999, 1'b0);  wait_done(20);
    @(posedge clk); #1;
    do_start(4'd0, 10'd0, 1'b1, 16'h0000, 1'b0);    wait_done(20);
    @(posedge clk); #1;
    do_start(4'd0, 10'd7, 1'b1, 16'h0007, 1'b0);    wait_done(20);
    @(posedge clk); #1;
    do_start(4'd0, 10'd1000, 1'b1, 16'hFFFF, 1'b1); wait_done(20);
    @(posedge clk); #1;
    do_start(4'd10, 10'd5, 1'b1, 16'hFFFF, 1'b1);   wait_done(20);
    @(posedge clk); #1;
    do_start(4'd2, 10'd50, 1'b1, 16'h2050, 1'b0);   wait_done(20);
    @(posedge clk); #1;

    // Second start while busy must be dropped.
    do_start(4'd0, 10'd123, 1'b1, 16'h0123, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    do_start(4'd0, 10'd456, 1'b0, 16'h0000, 1'b0);
    wait_done(20);
    // Start in the done cycle is accepted.
    do_start(4'd0, 10'd456, 1'b1, 16'h0456, 1'b0);
    wait_done(20);
    repeat (2) begin @(posedge clk); #1; end

    // Reset on the fifth cycle of a conversion aborts it.
    do_start(4'd0, 10'd888, 1'b0, 16'h0000, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_cleared("abort");
    repeat (15) begin @(posedge clk); #1; end
    chk_cleared("post_abort");
    do_start(4'd3, 10'd141, 1'b1, 16'h3141, 1'b0);  wait_done(20);
    repeat (3) begin @(posedge clk); #1; end

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
